// File: rtl/bcd_pkg.sv
// Shared types and elaboration-time helpers for the BCD modulo counter.
// Digit type, digit limit, constant-to-BCD conversion and BCD validity check.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Five digits so that 10**4 itself is representable as a bound.
    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] res;
        int r;
        res = '0;
        r = v;
        for (int i = 0; i < 5; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    function automatic logic bcd_valid(input logic [15:0] vec);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (vec[4*i +: 4] > BCD_MAX) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell: next-value logic with ripple carry and borrow.
// wrap overrides counting and forces the digit to wrap_to.
module bcd_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t q,
    input  logic       inc,
    input  logic       dec,
    input  logic       wrap,
    input  bcd_digit_t wrap_to,
    output bcd_digit_t next,
    output logic       carry,
    output logic       borrow
);

    assign carry  = inc & (q == BCD_MAX);
    assign borrow = dec & (q == 4'd0);

    always_comb begin
        next = q;
        if (wrap) begin
            next = wrap_to;
        end else if (inc) begin
            next = carry ? 4'd0 : q + 4'd1;
        end else if (dec) begin
            next = borrow ? BCD_MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Parametrised multi-digit BCD modulo-N counter with load, enable and cascade carry.
// Define BCD_UPDOWN_EN to add the up port and down counting.
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic              en,
`ifdef BCD_UPDOWN_EN
    input  logic              up,
`endif
    input  logic [4*DIGITS-1:0] d,
    output logic [4*DIGITS-1:0] q,
    output logic              co,
    output logic              err
);

    localparam int W = 4 * DIGITS;
    localparam int LIMIT = 10 ** DIGITS;
    localparam logic [19:0] MOD_BCD = to_bcd(MODULUS);
    localparam logic [19:0] TOP_BCD = to_bcd(MODULUS - 1);

    generate
        if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
            $error("bcd_mod_counter: DIGITS must be 1..4");
        end
        if (MODULUS < 2 || MODULUS > LIMIT) begin : g_bad_mod
            $error("bcd_mod_counter: MODULUS must be 2..10**DIGITS");
        end
    endgenerate

    logic          dir_up;
    logic          terminal;
    logic          d_ok;
    logic [15:0]   dx;
    logic [W-1:0]  nxt;
    logic [DIGITS:0] ci;
    logic [DIGITS:0] bi;

`ifdef BCD_UPDOWN_EN
    assign dir_up = up;
`else
    assign dir_up = 1'b1;
`endif

    assign terminal = dir_up ? (q == TOP_BCD[W-1:0]) : (q == '0);
    assign co = en & ~clr & ~load & terminal;

    // Packed BCD orders like the number, so a plain compare is a range check.
    assign dx   = 16'(d);
    assign d_ok = bcd_valid(dx) && ({4'd0, dx} < MOD_BCD);

    assign ci[0] = dir_up;
    assign bi[0] = ~dir_up;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_dig
            bcd_digit u_dig (
                .q      (q[4*g +: 4]),
                .inc    (ci[g]),
                .dec    (bi[g]),
                .wrap   (terminal),
                .wrap_to(dir_up ? 4'd0 : TOP_BCD[4*g +: 4]),
                .next   (nxt[4*g +: 4]),
                .carry  (ci[g+1]),
                .borrow (bi[g+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            q   <= '0;
            err <= 1'b0;
        end else if (load) begin
            if (d_ok) begin
                q   <= d;
                err <= 1'b0;
            end else begin
                err <= 1'b1;
            end
        end else begin
            err <= 1'b0;
            if (en) q <= nxt;
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Self-checking bench: mod-60 stage cascaded into a mod-24 stage.
// Integer reference model, per-cycle compare, directed literal checks.
module tb_bcd_mod_counter;

`ifdef BCD_UPDOWN_EN
    localparam bit UPDN = 1'b1;
`else
    localparam bit UPDN = 1'b0;
`endif

    logic       clk;
    logic       clr, load, en, up, load1;
    logic [7:0] d, d1, q, q1;
    logic       co, co1, err, err1;
    logic       cb;

    int  total, bad;
    bit  checking;
    int  v0, v1;
    bit  e0, e1;

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) dut (
        .clk(clk), .clr(clr), .load(load), .en(en),
`ifdef BCD_UPDOWN_EN
        .up(up),
`endif
        .d(d), .q(q), .co(co), .err(err)
    );

    bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) dut1 (
        .clk(clk), .clr(clr), .load(load1), .en(co),
`ifdef BCD_UPDOWN_EN
        .up(up),
`endif
        .d(d1), .q(q1), .co(co1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dval(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [7:0] tobcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit mco(input int v, input bit e, input bit c,
                               input bit l, input bit u, input int m);
        return e && !c && !l && (u ? (v == m - 1) : (v == 0));
    endfunction

    task automatic mstep(inout int v, inout bit er, input bit c, input bit l,
                         input bit e, input bit u, input logic [7:0] dd,
                         input int m);
        if (c) begin
            v = 0;
            er = 0;
        end else if (l) begin
            if (dd[7:4] <= 9 && dd[3:0] <= 9 && dval(dd) < m) begin
                v = dval(dd);
                er = 0;
            end else begin
                er = 1;
            end
        end else begin
            er = 0;
            if (e) v = u ? (v + 1) % m : (v + m - 1) % m;
        end
    endtask

    always @(posedge clk) begin
        bit c0;
        c0 = mco(v0, en, clr, load, up, 60);
        mstep(v0, e0, clr, load, en, up, d, 60);
        mstep(v1, e1, clr, load1, c0, up, d1, 24);
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            bit c0;
            c0 = mco(v0, en, clr, load, up, 60);
            chk("q", 32'(q), 32'(tobcd(v0)));
            chk("err", 32'(err), 32'(e0));
            chk("co", 32'(co), 32'(c0));
            chk("q1", 32'(q1), 32'(tobcd(v1)));
            chk("err1", 32'(err1), 32'(e1));
            chk("co1", 32'(co1), 32'(mco(v1, c0, clr, load1, up, 24)));
        end
    end

    task automatic apply(input bit c, input bit l, input bit e, input bit u,
                         input logic [7:0] dd);
        clr  = c;
        load = l;
        en   = e;
        up   = UPDN ? u : 1'b1;
        d    = dd;
        #1 cb = co;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        checking = 0;
        v0 = 0;
        v1 = 0;
        e0 = 0;
        e1 = 0;
        load1 = 0;
        d1 = 8'h00;

        apply(1, 0, 0, 1, 8'h00);
        checking = 1;

        apply(0, 1, 0, 1, 8'h37);
        chk("lit_load37", 32'(q), 32'h37);
        apply(1, 0, 1, 1, 8'h00);
        chk("lit_clr_q", 32'(q), 32'h00);
        chk("lit_clr_err", 32'(err), 32'h0);
        chk("lit_clr_co", 32'(cb), 32'h0);
        apply(1, 0, 1, 1, 8'h00);
        chk("lit_clr_hold", 32'(q), 32'h00);

        apply(0, 1, 0, 1, 8'h57);
        apply(0, 0, 1, 1, 8'h00);
        chk("lit_58", 32'(q), 32'h58);
        apply(0, 0, 1, 1, 8'h00);
        chk("lit_59", 32'(q), 32'h59);
        apply(0, 0, 1, 1, 8'h00);
        chk("lit_co59", 32'(cb), 32'h1);
        chk("lit_wrap00", 32'(q), 32'h00);
        apply(0, 0, 1, 1, 8'h00);
        chk("lit_co00", 32'(cb), 32'h0);
        chk("lit_01", 32'(q), 32'h01);

        apply(0, 1, 0, 1, 8'h60);
        chk("lit_ld60_q", 32'(q), 32'h01);
        chk("lit_ld60_err", 32'(err), 32'h1);
        apply(0, 1, 0, 1, 8'h3A);
        chk("lit_ld3A_q", 32'(q), 32'h01);
        chk("lit_ld3A_err", 32'(err), 32'h1);
        apply(0, 1, 0, 1, 8'h45);
        chk("lit_ld45_q", 32'(q), 32'h45);
        chk("lit_ld45_err", 32'(err), 32'h0);

        apply(0, 1, 0, 1, 8'h12);
        apply(0, 1, 1, 1, 8'h30);
        chk("lit_load_wins", 32'(q), 32'h30);
        apply(0, 1, 0, 1, 8'h09);
        apply(0, 0, 1, 1, 8'h00);
        chk("lit_09_10", 32'(q), 32'h10);

        if (UPDN) begin
            apply(0, 1, 0, 0, 8'h01);
            apply(0, 0, 1, 0, 8'h00);
            chk("lit_dn_co01", 32'(cb), 32'h0);
            chk("lit_dn_00", 32'(q), 32'h00);
            apply(0, 0, 1, 0, 8'h00);
            chk("lit_dn_co00", 32'(cb), 32'h1);
            chk("lit_dn_59", 32'(q), 32'h59);
            apply(0, 0, 1, 0, 8'h00);
            chk("lit_dn_58", 32'(q), 32'h58);
        end

        load1 = 1;
        d1 = 8'h23;
        apply(0, 1, 0, 1, 8'h59);
        load1 = 0;
        chk("lit_cas_q1_23", 32'(q1), 32'h23);
        apply(0, 0, 1, 1, 8'h00);
        chk("lit_cas_q0", 32'(q), 32'h00);
        chk("lit_cas_q1", 32'(q1), 32'h00);
        apply(0, 0, 1, 1, 8'h00);
        chk("lit_cas_q1_hold", 32'(q1), 32'h00);

        for (int i = 0; i < 600; i++) begin
            bit c, l, e, u;
            logic [7:0] dd;
            c = ($urandom_range(0, 99) < 3);
            l = ($urandom_range(0, 99) < 15);
            e = ($urandom_range(0, 99) < 75);
            u = ($urandom_range(0, 99) < 60);
            dd = ($urandom_range(0, 1) == 1) ? tobcd($urandom_range(0, 69))
                                               : 8'($urandom);
            load1 = ($urandom_range(0, 99) < 5);
            d1 = tobcd($urandom_range(0, 29));
            apply(c, l, e, u, dd);
        end

        load1 = 0;
        apply(0, 0, 0, 1, 8'h00);
        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
